// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source.
// Walks a horizontal/vertical pixel counter pair across the whole raster
// (visible area plus porches and sync) and registers the sync, blanking
// and coordinate outputs one cycle behind the counters. Defaults give
// 640x480@60 from a 25 MHz pixel clock.
module vga_timing_gen #(
    parameter int H_PIXELS = 640,
    parameter int H_FP     = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BP     = 48,
    parameter int H_POL    = 0,
    parameter int V_PIXELS = 480,
    parameter int V_FP     = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BP     = 33,
    parameter int V_POL    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic        h_sync,
    output logic        v_sync,
    output logic        disp_ena,
    output logic [31:0] column,
    output logic [31:0] row,
    output logic        n_blank,
    output logic        n_sync,
    output logic        frame_start
);

    localparam int H_PERIOD = H_PIXELS + H_FP + H_PULSE + H_BP;
    localparam int V_PERIOD = V_PIXELS + V_FP + V_PULSE + V_BP;

    // Full-width 12-bit boundaries so every compare is unsigned and exact.
    localparam logic [11:0] H_VIS        = 12'(H_PIXELS);
    localparam logic [11:0] H_SYNC_START = 12'(H_PIXELS + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_PIXELS + H_FP + H_PULSE);
    localparam logic [11:0] H_LAST       = 12'(H_PERIOD - 1);

    localparam logic [11:0] V_VIS        = 12'(V_PIXELS);
    localparam logic [11:0] V_SYNC_START = 12'(V_PIXELS + V_FP);
    localparam logic [11:0] V_SYNC_END   = 12'(V_PIXELS + V_FP + V_PULSE);
    localparam logic [11:0] V_LAST       = 12'(V_PERIOD - 1);

    // Active sync levels; the idle level is simply the inverse.
    localparam logic H_ACT = (H_POL != 0);
    localparam logic V_ACT = (V_POL != 0);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        h_in_sync;
    logic        v_in_sync;
    logic        h_visible;
    logic        v_visible;

    assign h_wrap    = (h_cnt == H_LAST);
    assign v_wrap    = (v_cnt == V_LAST);
    assign h_in_sync = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    assign v_in_sync = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    assign h_visible = (h_cnt < H_VIS);
    assign v_visible = (v_cnt < V_VIS);

    // The DAC blank pin follows display enable; sync-on-green is unused.
    assign n_blank = disp_ena;
    assign n_sync  = 1'b0;

    // Raster position counters; the line counter only steps when a line wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 12'd1;
                end
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Outputs decoded from the pre-increment position, held while pix_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync      <= ~H_ACT;
            v_sync      <= ~V_ACT;
            disp_ena    <= 1'b0;
            column      <= '0;
            row         <= '0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            h_sync      <= h_in_sync ? H_ACT : ~H_ACT;
            v_sync      <= v_in_sync ? V_ACT : ~V_ACT;
            disp_ena    <= h_visible && v_visible;
            if (h_visible) begin
                column <= {20'd0, h_cnt};
            end
            if (v_visible) begin
                row <= {20'd0, v_cnt};
            end
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the VGA raster timing that drives the test-pattern and image-generator blocks: horizontal/vertical sync, display enable, and the current pixel coordinates. It runs from the single pixel clock (25 MHz for the default 640x480@60 mode). It is the source end of the `disp_ena`/`row`/`column` interface that pixel generators consume, and it also drives the sync and blank pins of the board DAC.

## Interface
Parameters:
- `H_PIXELS`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_PULSE`, 96: hsync pulse width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `H_POL`, 0: hsync active level
- `V_PIXELS`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_PULSE`, 2: vsync pulse width, lines
- `V_BP`, 33: vertical back porch, lines
- `V_POL`, 0: vsync active level

Ports:
- `clk`  in  1  pixel clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-advance enable; tie high for full-rate operation
- `h_sync`  out  1  horizontal sync, level per `H_POL`
- `v_sync`  out  1  vertical sync, level per `V_POL`
- `disp_ena`  out  1  1 = visible pixel, 0 = blanking
- `column`  out  32  horizontal pixel coordinate, 0..H_PIXELS-1
- `row`  out  32  vertical pixel coordinate, 0..V_PIXELS-1
- `n_blank`  out  1  DAC blank, active low; equals `disp_ena`
- `n_sync`  out  1  DAC sync-on-green; constant 0
- `frame_start`  out  1  one-cycle pulse marking pixel (0,0)

## Operation
- Derived periods: H_PERIOD = H_PIXELS+H_FP+H_PULSE+H_BP (800); V_PERIOD = V_PIXELS+V_FP+V_PULSE+V_BP (525).
- Internal counters: `h_cnt`, 0..H_PERIOD-1, and `v_cnt`, 0..V_PERIOD-1. Both are 0 after reset.
- Each cycle with `pix_en`=1 and `reset`=0:
  - `h_cnt` increments.
  - At H_PERIOD-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - `v_cnt` wraps from V_PERIOD-1 to 0 only when `h_cnt` also wraps.
- Each enabled cycle, the outputs are registered from the pre-increment position (`h_cnt`,`v_cnt`):
  - `h_sync` = `H_POL` when H_PIXELS+H_FP <= `h_cnt` < H_PIXELS+H_FP+H_PULSE (656..751); otherwise ~`H_POL`.
  - `v_sync` = `V_POL` when V_PIXELS+V_FP <= `v_cnt` < V_PIXELS+V_FP+V_PULSE (490..491); otherwise ~`V_POL`.
  - `disp_ena` = (`h_cnt` < H_PIXELS) && (`v_cnt` < V_PIXELS).
  - `column` = `h_cnt`, zero-extended, when `h_cnt` < H_PIXELS; otherwise it holds its last value.
  - `row` = `v_cnt`, zero-extended, when `v_cnt` < V_PIXELS; otherwise it holds its last value.
  - `frame_start` = 1 only when `h_cnt`=0 and `v_cnt`=0.
- When `pix_en`=0, the counters and all registered outputs hold. `frame_start` is forced to 0 in those cycles, so a pulse lasts exactly one cycle.
- Reset values of the outputs:
  - `h_sync`=~`H_POL`, `v_sync`=~`V_POL`
  - `disp_ena`=0, `n_blank`=0, `n_sync`=0
  - `column`=0, `row`=0
  - `frame_start`=0
- Reset mid-frame: reset takes effect at the next edge and overrides `pix_en`. The first enabled cycle after reset release emits position (0,0).
- Arithmetic: counters are 12 bits wide. Comparisons are unsigned and use full-width constants. Parameters are legal when H_PERIOD <= 4096 and V_PERIOD <= 4096.

## Timing
- Latency is 1 cycle: the outputs for position (h,v) appear the cycle after the counters hold (h,v).
- With `pix_en` tied high:
  - Line = 800 cycles; frame = 420 000 cycles.
  - `frame_start` period is 420 000 cycles.
- `h_sync` asserts 656 enabled cycles after line start and lasts 96 cycles.
- `v_sync` spans lines 490–491, i.e. 1600 cycles.
- `disp_ena` is high for 640 consecutive cycles on each of lines 0..479 and low for all of lines 480..524.
- Sync edges align with `h_cnt` boundaries. `v_sync` changes coincident with `h_cnt`=0 output.

## Test plan
- Reset:
  - Hold `reset` 5 cycles with `pix_en`=1 -> `h_sync`=`v_sync`=1 (default polarity), `disp_ena`=0, `row`=`column`=0, `frame_start`=0.
  - Release -> the first cycle shows `disp_ena`=1, `column`=0, `row`=0, `frame_start`=1.
- Line 0 with `pix_en`=1:
  - `column` counts 0..639 with `disp_ena`=1, then `disp_ena`=0 for 160 cycles.
  - `h_sync`=0 exactly for `h_cnt` 656..751.
  - `row` stays 0, then becomes 1 at the next line's first pixel.
- Full frame:
  - `frame_start` pulses are spaced 420 000 cycles apart.
  - `v_sync` is low for exactly 1600 cycles, starting at line 490.
  - `row` holds 479 during lines 480..524.
- `pix_en` gating:
  - Toggle `pix_en` 1/0 every cycle -> line = 1600 cycles.
  - Outputs are unchanged during `pix_en`=0 cycles.
  - `frame_start` stays high for exactly one clock per frame.
- Polarity parameters: `H_POL`=1, `V_POL`=1 -> syncs idle 0 and pulse 1 at the same positions and widths.
- Reset mid-frame:
  - Assert `reset` for one cycle at line 300, `h_cnt`=400 -> the next cycle shows reset values.
  - After release, the raster restarts at (0,0) with `frame_start`=1.
